// File: rtl/mem_arb_pkg.sv
// Shared encodings for the multicycle-core memory arbiter.
package mem_arb_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last time is chosen.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic c_req,
    input  logic l_req,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_port
);

    always_comb begin
        gnt_valid = c_req | l_req;
        if (c_req && l_req) begin
            gnt_port = ~last_grant;
        end else if (l_req) begin
            gnt_port = PORT_LOAD;
        end else begin
            gnt_port = PORT_CORE;
        end
    end

endmodule

// File: rtl/mem_arbiter_mc.sv
// Arbitrates the unified memory between the core and the loader port, one transaction in
// flight, with a bus timeout that aborts a hung access and raises a sticky error.
module mem_arbiter_mc
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              m_req_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] c_rdata_q, l_rdata_q;
    logic              owner_q, last_grant_q;
    logic [CntW-1:0]   count_q;
    logic              err_q;
    logic              gnt_valid, gnt_port;
    logic              expired;

    rr_arb2 u_rr_arb2 (
        .c_req      (c_req),
        .l_req      (l_req),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    assign expired = (count_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_valid) state_d = S_BUSY;
            S_BUSY:  if (m_ack || expired) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        c_ack = (state_q == S_DONE) && (owner_q == PORT_CORE);
        l_ack = (state_q == S_DONE) && (owner_q == PORT_LOAD);
    end

    // Request registers, timeout counter and per-port read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            c_rdata_q    <= '0;
            l_rdata_q    <= '0;
            owner_q      <= PORT_CORE;
            last_grant_q <= PORT_LOAD;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        m_req_q      <= 1'b1;
                        m_we_q       <= (gnt_port == PORT_LOAD) ? l_we    : c_we;
                        m_addr_q     <= (gnt_port == PORT_LOAD) ? l_addr  : c_addr;
                        m_wdata_q    <= (gnt_port == PORT_LOAD) ? l_wdata : c_wdata;
                        owner_q      <= gnt_port;
                        last_grant_q <= gnt_port;
                        count_q      <= '0;
                    end
                end
                S_BUSY: begin
                    if (m_ack) begin
                        m_req_q <= 1'b0;
                        if (!m_we_q) begin
                            if (owner_q == PORT_LOAD) l_rdata_q <= m_rdata;
                            else                      c_rdata_q <= m_rdata;
                        end
                    end else if (expired) begin
                        // Abort: poison the owner's read data even for a write.
                        m_req_q <= 1'b0;
                        err_q   <= 1'b1;
                        if (owner_q == PORT_LOAD) l_rdata_q <= '1;
                        else                      c_rdata_q <= '1;
                    end else begin
                        count_q <= count_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign c_rdata     = c_rdata_q;
    assign l_rdata     = l_rdata_q;
    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc with a short bus timeout.
module tb_mem_arbiter_mc;

    logic        clk, rst;
    logic        c_req, c_we, c_ack, l_req, l_we, l_ack;
    logic [31:0] c_addr, c_wdata, c_rdata, l_addr, l_wdata, l_rdata;
    logic        m_req, m_we, m_ack, busy, owner, timeout_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter_mc #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .c_req       (c_req),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_ack       (c_ack),
        .c_rdata     (c_rdata),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_ack       (l_ack),
        .l_rdata     (l_rdata),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        m_ack = 0; m_rdata = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
        checks++; if ({c_ack, l_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", {c_ack, l_ack}); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b expected 0", owner); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        checks++; if ({c_rdata, l_rdata, m_addr} !== 96'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {c_rdata, l_rdata, m_addr}); end
    endtask

    task automatic test_core_read();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        step();
        checks++; if ({m_req, m_we, owner, busy} !== 4'b1001) begin errors++; $display("FAIL cr_grant: got %b expected 1001", {m_req, m_we, owner, busy}); end
        checks++; if (m_addr !== 32'h10) begin errors++; $display("FAIL cr_m_addr: got %h expected 00000010", m_addr); end
        step();
        checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL cr_early_ack: got %b expected 0", c_ack); end
        step();
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        step();
        m_ack = 0;
        checks++; if ({c_ack, l_ack, m_req} !== 3'b100) begin errors++; $display("FAIL cr_ack: got %b expected 100", {c_ack, l_ack, m_req}); end
        checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cr_rdata: got %h expected deadbeef", c_rdata); end
        c_req = 0;
        step();
        checks++; if ({c_ack, busy} !== 2'b00) begin errors++; $display("FAIL cr_pulse: got %b expected 00", {c_ack, busy}); end
        checks++; if (c_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cr_hold: got %h expected deadbeef", c_rdata); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        c_req = 1; c_we = 0; c_addr = 32'h100;
        l_req = 1; l_we = 0; l_addr = 32'h200;
        for (int r = 0; r < 4; r++) begin
            logic        exp_own;
            logic [31:0] exp_addr;
            exp_own  = (r % 2) == 1;
            exp_addr = exp_own ? 32'h200 : 32'h100;
            step();
            checks++; if (owner !== exp_own) begin errors++; $display("FAIL rr_owner_%0d: got %b expected %b", r, owner, exp_own); end
            checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL rr_addr_%0d: got %h expected %h", r, m_addr, exp_addr); end
            m_ack = 1; m_rdata = 32'hA000_0000 + r;
            step();
            m_ack = 0;
            checks++; if ({c_ack, l_ack} !== {~exp_own, exp_own}) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", r, {c_ack, l_ack}, {~exp_own, exp_own}); end
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d: got %b expected 0", r, busy); end
        end
        c_req = 0; l_req = 0;
        checks++; if (c_rdata !== 32'hA000_0002) begin errors++; $display("FAIL rr_c_rdata: got %h expected a0000002", c_rdata); end
        checks++; if (l_rdata !== 32'hA000_0003) begin errors++; $display("FAIL rr_l_rdata: got %h expected a0000003", l_rdata); end
    endtask

    task automatic test_loader_write();
        l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h12345678;
        step();
        checks++; if ({m_req, m_we, owner} !== 3'b111) begin errors++; $display("FAIL lw_grant: got %b expected 111", {m_req, m_we, owner}); end
        checks++; if (m_wdata !== 32'h12345678) begin errors++; $display("FAIL lw_wdata: got %h expected 12345678", m_wdata); end
        checks++; if (m_addr !== 32'h40) begin errors++; $display("FAIL lw_addr: got %h expected 00000040", m_addr); end
        m_ack = 1; m_rdata = 32'hCAFEF00D;
        checks++; if (l_ack !== 1'b0) begin errors++; $display("FAIL lw_early_ack: got %b expected 0", l_ack); end
        step();
        m_ack = 0;
        checks++; if ({c_ack, l_ack} !== 2'b01) begin errors++; $display("FAIL lw_ack: got %b expected 01", {c_ack, l_ack}); end
        checks++; if (l_rdata !== 32'hA000_0003) begin errors++; $display("FAIL lw_rdata_kept: got %h expected a0000003", l_rdata); end
        l_req = 0; l_we = 0;
        step();
    endtask

    task automatic test_ack_ignored_idle();
        m_ack = 1; m_rdata = 32'h77777777;
        step();
        m_ack = 0;
        checks++; if ({busy, m_req, c_ack, l_ack} !== 4'b0000) begin errors++; $display("FAIL idle_ack: got %b expected 0000", {busy, m_req, c_ack, l_ack}); end
        checks++; if (c_rdata !== 32'hA000_0002) begin errors++; $display("FAIL idle_ack_rdata: got %h expected a0000002", c_rdata); end
    endtask

    task automatic test_ack_at_timeout();
        c_req = 1; c_we = 0; c_addr = 32'h80;
        step();
        step();
        step();
        step();
        checks++; if ({busy, m_req} !== 2'b11) begin errors++; $display("FAIL at_still_busy: got %b expected 11", {busy, m_req}); end
        m_ack = 1; m_rdata = 32'h55AA55AA;
        step();
        m_ack = 0;
        checks++; if (c_ack !== 1'b1) begin errors++; $display("FAIL at_ack: got %b expected 1", c_ack); end
        checks++; if (c_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL at_rdata: got %h expected 55aa55aa", c_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL at_err: got %b expected 0", timeout_err); end
        c_req = 0;
        step();
    endtask

    task automatic test_timeout();
        c_req = 1; c_we = 0; c_addr = 32'h84;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({m_req, c_ack} !== 2'b10) begin errors++; $display("FAIL to_wait_%0d: got %b expected 10", i, {m_req, c_ack}); end
        end
        step();
        checks++; if ({m_req, c_ack, l_ack} !== 3'b010) begin errors++; $display("FAIL to_abort: got %b expected 010", {m_req, c_ack, l_ack}); end
        checks++; if (c_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL to_rdata: got %h expected ffffffff", c_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", timeout_err); end
        c_req = 0;
        step();
        l_req = 1; l_we = 0; l_addr = 32'h44;
        step();
        step();
        m_ack = 1; m_rdata = 32'h0BADF00D;
        step();
        m_ack = 0;
        checks++; if (l_ack !== 1'b1) begin errors++; $display("FAIL to_good_ack: got %b expected 1", l_ack); end
        checks++; if (l_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL to_good_rdata: got %h expected 0badf00d", l_rdata); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
        l_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        c_req = 1; c_we = 0; c_addr = 32'h90;
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b expected 1", busy); end
        rst = 1;
        step();
        checks++; if ({busy, m_req, c_ack, l_ack, owner} !== 5'b00000) begin errors++; $display("FAIL rm_state: got %b expected 00000", {busy, m_req, c_ack, l_ack, owner}); end
        checks++; if ({timeout_err, c_rdata} !== 33'h0) begin errors++; $display("FAIL rm_regs: got %h expected 0", {timeout_err, c_rdata}); end
        rst = 0; c_req = 0;
        m_ack = 1; m_rdata = 32'h11111111;
        step();
        m_ack = 0;
        checks++; if ({busy, c_ack, l_ack} !== 3'b000) begin errors++; $display("FAIL rm_late_ack: got %b expected 000", {busy, c_ack, l_ack}); end
        checks++; if (c_rdata !== 32'h0) begin errors++; $display("FAIL rm_late_rdata: got %h expected 0", c_rdata); end
        step();
        checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL rm_no_pulse: got %b expected 0", c_ack); end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_round_robin();
        test_loader_write();
        test_ack_ignored_idle();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
